writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final pipeline stage. Drives the register-bank write ports (WE1/WE2, Rd, WD1, WD2) read by instruction decode.
//  Accepts one retired instruction per handshake from the MEM stage and commits scalar 24b or vector 144b results.
//  Assembles vector loads from LANES serial 24b memory beats before issuing a single vector write.
//  Exports pending-write status to the decode stage for hazard detection.
// PARAMETERS
//  DATA_W     24   scalar word width; also the width of one vector lane
//  LANES      6    lanes per vector register (vector width = DATA_W*LANES = 144)
//  IDX_W      4    register index width
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        MEM stage presents a retired instruction
//  in_ready    out  1        unit can accept; transfer occurs when in_valid & in_ready
//  regWrite    in   1        scalar write-back requested
//  regWriteV   in   1        vector write-back requested
//  memToReg    in   1        result comes from memory (else from ALU)
//  in_rd       in   IDX_W    destination register
//  alu_res     in   DATA_W   scalar ALU result
//  alu_resV    in   144      vector ALU result
//  mem_data    in   DATA_W   memory read beat
//  beat_valid  in   1        mem_data holds the next vector-load lane (only used in ASSEMBLE)
//  flush       in   1        abort the in-progress vector-load assembly
//  WE1         out  1        scalar bank write enable, 1-cycle pulse
//  WE2         out  1        vector bank write enable, 1-cycle pulse
//  Rd          out  IDX_W    write index, shared by both banks
//  WD1         out  DATA_W   scalar write data
//  WD2         out  144      vector write data; lane k = WD2[DATA_W*k +: DATA_W]
//  pend_valid  out  1        a write to pend_rd is assembling or on the ports this cycle
//  pend_rd     out  IDX_W    destination of the pending write
//  pend_vec    out  1        pending write targets the vector bank
// BEHAVIOUR
//  Reset (sync): WE1=WE2=0, Rd=0, WD1=0, WD2=0, pend_*=0, state=IDLE, lane counter=0, partial data cleared.
//  All outputs are registered. Rd/WD1/WD2 hold their last values while WE1/WE2 are low.
//  States: IDLE, ASSEMBLE. in_ready = (state==IDLE).
//  IDLE, handshake accepted, cycle T:
//   - regWriteV & memToReg  -> lane0 <= mem_data; cnt <= 1; go ASSEMBLE; latch in_rd.
//   - regWriteV & !memToReg -> at T+1: WE2=1, Rd=in_rd, WD2=alu_resV.
//   - regWrite & !regWriteV -> at T+1: WE1=1, Rd=in_rd, WD1 = memToReg ? mem_data : alu_res.
//   - regWriteV & regWrite  -> regWriteV takes priority; WE1 stays 0.
//   - neither               -> bubble; no enable asserted.
//  ASSEMBLE: each cycle with beat_valid, lane[cnt] <= mem_data and cnt++.
//   When lane LANES-1 is captured in cycle T, at T+1: WE2=1, Rd=latched rd, WD2=assembled vector;
//   state returns to IDLE at T+1, so in_ready=1 at T+1.
//   beat_valid low: hold state and cnt; no timeout.
//  flush: honoured only in ASSEMBLE. Returns to IDLE next cycle, no WE2, cnt=0.
//   flush in the same cycle as the final beat: flush wins, no write.
//   flush in IDLE: ignored; an accepted instruction commits normally.
//  Enables: WE1 and WE2 are never high in the same cycle. Each asserts for exactly 1 cycle per committed instruction.
//  Pending status:
//   - pend_valid=1 with pend_rd=latched rd and pend_vec=1 throughout ASSEMBLE.
//   - pend_valid=1 on any cycle WE1 or WE2 is high, with pend_rd=Rd and pend_vec=WE2.
//   - pend_valid=0 otherwise.
//  Throughput: 1 scalar/vector-ALU instruction per cycle; vector load occupies LANES cycles minimum.
//  rst asserted mid-ASSEMBLE: partial data discarded and no write issued.
// TESTING
//  1 scalar ALU: accept regWrite=1, in_rd=3, alu_res=0x00ABCD -> next cycle WE1=1, Rd=3, WD1=0x00ABCD, WE2=0.
//  2 scalar load: regWrite=1, memToReg=1, mem_data=0xFFFFFF, in_rd=7 -> next cycle WE1=1, WD1=0xFFFFFF.
//  3 vector load: lanes 1..6 on consecutive beats, one beat_valid gap after lane 3, in_rd=5
//    -> in_ready=0 for 6 cycles; then WE2=1, WD2=0x000006_000005_000004_000003_000002_000001 (lane6..lane1), pend_rd=5 throughout.
//  4 flush with the final beat of a vector load -> no WE2; in_ready=1 next cycle; a following scalar write commits 1 cycle after acceptance.
//  5 back-to-back: vector ALU (Rd=2) then scalar (Rd=4) on consecutive cycles -> WE2 then WE1 on consecutive cycles, never overlapping.
//  6 rst raised during lane 3 of an assembly -> all outputs 0 next cycle; no WE2 afterwards.

Source files
------------

// File: rtl/writeback_unit.sv
// Final pipeline stage: commits scalar/vector results to the register banks and
// assembles vector loads from serial memory beats before a single vector write.
module writeback_unit #(
    parameter int DATA_W = 24,
    parameter int LANES  = 6,
    parameter int IDX_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      regWrite,
    input  logic                      regWriteV,
    input  logic                      memToReg,
    input  logic [IDX_W-1:0]          in_rd,
    input  logic [DATA_W-1:0]         alu_res,
    input  logic [DATA_W*LANES-1:0]   alu_resV,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic                      beat_valid,
    input  logic                      flush,
    output logic                      WE1,
    output logic                      WE2,
    output logic [IDX_W-1:0]          Rd,
    output logic [DATA_W-1:0]         WD1,
    output logic [DATA_W*LANES-1:0]   WD2,
    output logic                      pend_valid,
    output logic [IDX_W-1:0]          pend_rd,
    output logic                      pend_vec
);

    localparam int VEC_W = DATA_W * LANES;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    typedef enum logic {IDLE, ASSEMBLE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   rd_lat, rd_lat_n;
    logic [DATA_W-1:0]  lanes [LANES];
    logic               cap_en;
    logic [CNT_W-1:0]   cap_idx;
    logic [VEC_W-1:0]   assembled;

    logic               we1_n, we2_n;
    logic [IDX_W-1:0]   rd_n;
    logic [DATA_W-1:0]  wd1_n;
    logic [VEC_W-1:0]   wd2_n;
    logic               pv_n, pvec_n;
    logic [IDX_W-1:0]   prd_n;

    assign in_ready = (state == IDLE);

    // The lane arriving this cycle is merged directly so the final beat needs no extra cycle.
    always_comb begin
        assembled = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            assembled[k*DATA_W +: DATA_W] = (CNT_W'(k) == cnt) ? mem_data : lanes[k];
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rd_lat_n = rd_lat;
        cap_en   = 1'b0;
        cap_idx  = cnt;
        we1_n    = 1'b0;
        we2_n    = 1'b0;
        rd_n     = Rd;
        wd1_n    = WD1;
        wd2_n    = WD2;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (regWriteV) begin
                        if (memToReg) begin
                            cap_en   = 1'b1;
                            cap_idx  = '0;
                            cnt_n    = CNT_W'(1);
                            rd_lat_n = in_rd;
                            state_n  = ASSEMBLE;
                        end else begin
                            we2_n = 1'b1;
                            rd_n  = in_rd;
                            wd2_n = alu_resV;
                        end
                    end else if (regWrite) begin
                        we1_n = 1'b1;
                        rd_n  = in_rd;
                        wd1_n = memToReg ? mem_data : alu_res;
                    end
                end
            end
            ASSEMBLE: begin
                if (flush) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (beat_valid) begin
                    cap_en = 1'b1;
                    if (cnt == LAST) begin
                        we2_n   = 1'b1;
                        rd_n    = rd_lat;
                        wd2_n   = assembled;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        pv_n   = (state_n == ASSEMBLE) || we1_n || we2_n;
        pvec_n = (state_n == ASSEMBLE) || we2_n;
        if (state_n == ASSEMBLE)
            prd_n = rd_lat_n;
        else if (we1_n || we2_n)
            prd_n = rd_n;
        else
            prd_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_lat     <= '0;
            WE1        <= 1'b0;
            WE2        <= 1'b0;
            Rd         <= '0;
            WD1        <= '0;
            WD2        <= '0;
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            pend_vec   <= 1'b0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lanes[k] <= '0;
            end
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rd_lat     <= rd_lat_n;
            WE1        <= we1_n;
            WE2        <= we2_n;
            Rd         <= rd_n;
            WD1        <= wd1_n;
            WD2        <= wd2_n;
            pend_valid <= pv_n;
            pend_rd    <= prd_n;
            pend_vec   <= pvec_n;
            if (cap_en) begin
                lanes[cap_idx] <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected bank writes,
// a negedge monitor pops and compares whenever WE1 or WE2 is high.
module tb_writeback_unit;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic          regWrite, regWriteV, memToReg;
    logic [3:0]    in_rd;
    logic [23:0]   alu_res;
    logic [143:0]  alu_resV;
    logic [23:0]   mem_data;
    logic          beat_valid, flush;
    logic          WE1, WE2;
    logic [3:0]    Rd;
    logic [23:0]   WD1;
    logic [143:0]  WD2;
    logic          pend_valid;
    logic [3:0]    pend_rd;
    logic          pend_vec;

    writeback_unit #(.DATA_W(24), .LANES(6), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .regWrite(regWrite), .regWriteV(regWriteV), .memToReg(memToReg),
        .in_rd(in_rd), .alu_res(alu_res), .alu_resV(alu_resV),
        .mem_data(mem_data), .beat_valid(beat_valid), .flush(flush),
        .WE1(WE1), .WE2(WE2), .Rd(Rd), .WD1(WD1), .WD2(WD2),
        .pend_valid(pend_valid), .pend_rd(pend_rd), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vec;
        logic [3:0]   rd;
        logic [23:0]  wd1;
        logic [143:0] wd2;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write-enable pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (mon_en && (WE1 || WE2)) begin
            exp_t e;
            chk("we_exclusive", {143'd0, WE1 & WE2}, 144'd0);
            if (expq.size() == 0) begin
                chk("unexpected_write", {142'd0, WE1, WE2}, 144'd0);
            end else begin
                e = expq.pop_front();
                chk("WE1", {143'd0, WE1}, {143'd0, ~e.vec});
                chk("WE2", {143'd0, WE2}, {143'd0, e.vec});
                chk("Rd", {140'd0, Rd}, {140'd0, e.rd});
                if (e.vec) chk("WD2", WD2, e.wd2);
                else       chk("WD1", {120'd0, WD1}, {120'd0, e.wd1});
                chk("pend_valid_on_write", {143'd0, pend_valid}, 144'd1);
                chk("pend_rd_on_write", {140'd0, pend_rd}, {140'd0, e.rd});
                chk("pend_vec_on_write", {143'd0, pend_vec}, {143'd0, e.vec});
            end
        end
    end

    task automatic idle_in();
        in_valid = 0; regWrite = 0; regWriteV = 0; memToReg = 0;
        in_rd = '0; alu_res = '0; alu_resV = '0; mem_data = '0;
        beat_valid = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk(name, {143'd0, in_ready}, 144'd1);
    endtask

    task automatic drive(input logic rw, input logic rwv, input logic m2r, input logic [3:0] rd,
                         input logic [23:0] alu, input logic [143:0] aluv, input logic [23:0] mem);
        in_valid = 1; regWrite = rw; regWriteV = rwv; memToReg = m2r;
        in_rd = rd; alu_res = alu; alu_resV = aluv; mem_data = mem;
    endtask

    task automatic push(input logic vec, input logic [3:0] rd, input logic [23:0] wd1, input logic [143:0] wd2);
        exp_t e;
        e.vec = vec; e.rd = rd; e.wd1 = wd1; e.wd2 = wd2;
        expq.push_back(e);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_WE"}, {142'd0, WE1, WE2}, 144'd0);
        chk({name, "_Rd_WD1"}, {116'd0, Rd, WD1}, 144'd0);
        chk({name, "_WD2"}, WD2, 144'd0);
        chk({name, "_pend"}, {138'd0, pend_valid, pend_rd, pend_vec}, 144'd0);
    endtask

    localparam logic [143:0] VLOAD = 144'h000006_000005_000004_000003_000002_000001;
    localparam logic [143:0] VALU2 = 144'h111111_222222_333333_444444_555555_666666;

    initial begin
        int beats [6];
        idle_in();
        rst = 1;
        tick(); tick();
        rst = 0;
        mon_en = 1'b1;
        check_zero("reset");
        chk("reset_in_ready", {143'd0, in_ready}, 144'd1);

        // 1: scalar ALU
        drive(1, 0, 0, 4'd3, 24'h00ABCD, '0, 24'h0);
        push(0, 4'd3, 24'h00ABCD, '0);
        tick(); idle_in();

        // 2: scalar load
        drive(1, 0, 1, 4'd7, 24'h000055, '0, 24'hFFFFFF);
        push(0, 4'd7, 24'hFFFFFF, '0);
        tick(); idle_in();

        // bubble, then regWrite+regWriteV priority (vector ALU wins)
        drive(0, 0, 0, 4'd9, 24'h1, '0, 24'h2);
        tick(); idle_in();
        chk("bubble_no_we", {142'd0, WE1, WE2}, 144'd0);
        drive(1, 1, 0, 4'd8, 24'h777777, VALU2, 24'h0);
        push(1, 4'd8, '0, VALU2);
        tick(); idle_in();

        // 3: vector load with a gap after lane 3
        wait_ready("ready_before_vload");
        drive(0, 1, 1, 4'd5, '0, '0, 24'h000001);
        tick(); idle_in();
        beats = '{2, 3, 0, 4, 5, 6};
        foreach (beats[i]) begin
            chk("vload_in_ready_low", {143'd0, in_ready}, 144'd0);
            chk("vload_pend", {138'd0, pend_valid, pend_rd, pend_vec}, {138'd0, 1'b1, 4'd5, 1'b1});
            beat_valid = (beats[i] != 0);
            mem_data = 24'(beats[i]);
            if (i == 5) push(1, 4'd5, '0, VLOAD);
            tick();
        end
        idle_in();
        chk("vload_ready_after", {143'd0, in_ready}, 144'd1);

        // 4: flush together with the final beat
        drive(0, 1, 1, 4'd9, '0, '0, 24'h000011);
        tick(); idle_in();
        for (int i = 0; i < 5; i++) begin
            beat_valid = 1;
            mem_data = 24'h20 + 24'(i);
            flush = (i == 4);
            tick();
        end
        idle_in();
        chk("flush_in_ready", {143'd0, in_ready}, 144'd1);
        chk("flush_no_we2", {143'd0, WE2}, 144'd0);
        drive(1, 0, 0, 4'd1, 24'h123456, '0, 24'h0);
        push(0, 4'd1, 24'h123456, '0);
        tick(); idle_in();
        chk("after_flush_we1", {143'd0, WE1}, 144'd1);

        // flush in IDLE is ignored
        drive(1, 0, 0, 4'd12, 24'hC0FFEE, '0, 24'h0);
        flush = 1;
        push(0, 4'd12, 24'hC0FFEE, '0);
        tick(); idle_in();

        // 5: back-to-back vector ALU then scalar
        drive(0, 1, 0, 4'd2, '0, VALU2, 24'h0);
        push(1, 4'd2, '0, VALU2);
        tick();
        chk("b2b_we2", {142'd0, WE1, WE2}, 144'd1);
        drive(1, 0, 0, 4'd4, 24'h0BEEF0, '0, 24'h0);
        push(0, 4'd4, 24'h0BEEF0, '0);
        tick(); idle_in();
        chk("b2b_we1", {142'd0, WE1, WE2}, 144'd2);

        // 6: reset during lane 3 of an assembly
        drive(0, 1, 1, 4'd6, '0, '0, 24'h000001);
        tick(); idle_in();
        beat_valid = 1; mem_data = 24'h000002;
        tick();
        mem_data = 24'h000003; rst = 1;
        tick();
        rst = 0; idle_in();
        check_zero("rst_mid");
        chk("rst_mid_in_ready", {143'd0, in_ready}, 144'd1);
        beat_valid = 1; mem_data = 24'h4;
        for (int i = 0; i < 6; i++) tick();
        idle_in();
        tick(); tick();

        chk("queue_drained", 144'(expq.size()), 144'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
